conv_cache_fill_ctrl: RTL and testbench

CONV_CACHE_FILL_CTRL -- requirements
Module: conv_cache_fill_ctrl

---
 rtl/conv_cache_fill_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_conv_cache_fill_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_cache_fill_ctrl.sv
// Fills a double-banked convolution row cache from a row-major pixel stream and hands full banks to a reader.
// Optional CONV_CACHE_FILL_ZERO_PAD_EN: zero-fills the unused rows of a frame's final, partial bank.
module conv_cache_fill_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int IM_CACHE_DEPTH = 512,
    parameter int IM_CACHE_COUNT = 4,
    localparam int AW = $clog2(IM_CACHE_DEPTH),
    localparam int RW = $clog2(IM_CACHE_COUNT) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_in,
    input  logic [AW:0]               row_len_in,
    input  logic [15:0]               frame_rows_in,
    input  logic [DATA_WIDTH-1:0]     pix_data_in,
    input  logic                      pix_valid_in,
    output logic                      pix_ready_out,
    output logic [DATA_WIDTH-1:0]     cache_port_a_wrt_data_out,
    output logic [AW-1:0]             cache_port_a_wrt_addr_out,
    output logic [IM_CACHE_COUNT-1:0] cache_port_a_wrt_sel_out,
    output logic                      cache_port_a_wrt_en_out,
    output logic                      cache_blk_sel_out,
    output logic                      blk_valid_out,
    output logic [RW-1:0]             blk_rows_out,
    input  logic                      blk_release_in,
    output logic                      frame_done_out
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        WAIT_SWAP = 3'd2,
`ifdef CONV_CACHE_FILL_ZERO_PAD_EN
        PAD       = 3'd4,
`endif
        SWAP      = 3'd3
    } state_t;

    state_t state_reg, state_next;

    logic [AW:0]               row_len_reg;
    logic [15:0]               frame_rows_reg;
    logic [AW:0]               col_cnt_reg;
    logic [IM_CACHE_COUNT-1:0] row_sel_reg;
    logic [RW-1:0]             bank_rows_reg;
    logic [15:0]               frame_row_cnt_reg;
    logic [RW-1:0]             blk_rows_latch_reg;
    logic                      wrt_en_reg;
    logic [DATA_WIDTH-1:0]     wrt_data_reg;
    logic [AW-1:0]             wrt_addr_reg;
    logic [IM_CACHE_COUNT-1:0] wrt_sel_reg;
    logic                      blk_sel_reg;
    logic                      blk_valid_reg;
    logic [RW-1:0]             blk_rows_reg;

    logic col_last, bank_last, frame_last, rows_remain, reader_free, swap_enter;

    assign col_last    = (col_cnt_reg == row_len_reg - (AW+1)'(1));
    assign bank_last   = (bank_rows_reg == RW'(IM_CACHE_COUNT - 1));
    assign frame_last  = (frame_row_cnt_reg == frame_rows_reg - 16'd1);
    assign rows_remain = (frame_row_cnt_reg < frame_rows_reg);
    // A release arriving this cycle frees the reader bank immediately.
    assign reader_free = !blk_valid_reg || blk_release_in;
    assign swap_enter  = (state_reg == WAIT_SWAP) && reader_free;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start_in) state_next = FILL;
            FILL: begin
                if (pix_valid_in && col_last && (bank_last || frame_last)) begin
`ifdef CONV_CACHE_FILL_ZERO_PAD_EN
                    state_next = bank_last ? WAIT_SWAP : PAD;
`else
                    state_next = WAIT_SWAP;
`endif
                end
            end
`ifdef CONV_CACHE_FILL_ZERO_PAD_EN
            PAD: if (col_last && bank_last) state_next = WAIT_SWAP;
`endif
            WAIT_SWAP: if (reader_free) state_next = SWAP;
            SWAP: state_next = rows_remain ? FILL : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pix_ready_out  = (state_reg == FILL);
        frame_done_out = (state_reg == SWAP) && !rows_remain;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_len_reg        <= '0;
            frame_rows_reg     <= '0;
            col_cnt_reg        <= '0;
            row_sel_reg        <= '0;
            bank_rows_reg      <= '0;
            frame_row_cnt_reg  <= '0;
            blk_rows_latch_reg <= '0;
            wrt_en_reg         <= 1'b0;
            wrt_data_reg       <= '0;
            wrt_addr_reg       <= '0;
            wrt_sel_reg        <= '0;
        end else begin
            wrt_en_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_in) begin
                        row_len_reg       <= row_len_in;
                        frame_rows_reg    <= frame_rows_in;
                        col_cnt_reg       <= '0;
                        row_sel_reg       <= IM_CACHE_COUNT'(1);
                        bank_rows_reg     <= '0;
                        frame_row_cnt_reg <= '0;
                    end
                end
                FILL: begin
                    if (pix_valid_in) begin
                        wrt_en_reg   <= 1'b1;
                        wrt_data_reg <= pix_data_in;
                        wrt_addr_reg <= col_cnt_reg[AW-1:0];
                        wrt_sel_reg  <= row_sel_reg;
                        if (col_last) begin
                            col_cnt_reg       <= '0;
                            row_sel_reg       <= row_sel_reg << 1;
                            bank_rows_reg     <= bank_rows_reg + RW'(1);
                            frame_row_cnt_reg <= frame_row_cnt_reg + 16'd1;
                            if (bank_last || frame_last) begin
`ifdef CONV_CACHE_FILL_ZERO_PAD_EN
                                blk_rows_latch_reg <= RW'(IM_CACHE_COUNT);
`else
                                blk_rows_latch_reg <= bank_rows_reg + RW'(1);
`endif
                            end
                        end else begin
                            col_cnt_reg <= col_cnt_reg + (AW+1)'(1);
                        end
                    end
                end
`ifdef CONV_CACHE_FILL_ZERO_PAD_EN
                PAD: begin
                    wrt_en_reg   <= 1'b1;
                    wrt_data_reg <= '0;
                    wrt_addr_reg <= col_cnt_reg[AW-1:0];
                    wrt_sel_reg  <= row_sel_reg;
                    if (col_last) begin
                        col_cnt_reg   <= '0;
                        row_sel_reg   <= row_sel_reg << 1;
                        bank_rows_reg <= bank_rows_reg + RW'(1);
                    end else begin
                        col_cnt_reg <= col_cnt_reg + (AW+1)'(1);
                    end
                end
`endif
                SWAP: begin
                    col_cnt_reg   <= '0;
                    row_sel_reg   <= IM_CACHE_COUNT'(1);
                    bank_rows_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    // Bank handover registers change on entry to SWAP; the last write (if any) retires with the old select.
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_sel_reg   <= 1'b0;
            blk_valid_reg <= 1'b0;
            blk_rows_reg  <= '0;
        end else if (swap_enter) begin
            blk_sel_reg   <= ~blk_sel_reg;
            blk_valid_reg <= 1'b1;
            blk_rows_reg  <= blk_rows_latch_reg;
        end else if (blk_release_in && blk_valid_reg) begin
            blk_valid_reg <= 1'b0;
        end
    end

    assign cache_port_a_wrt_en_out   = wrt_en_reg;
    assign cache_port_a_wrt_data_out = wrt_data_reg;
    assign cache_port_a_wrt_addr_out = wrt_addr_reg;
    assign cache_port_a_wrt_sel_out  = wrt_sel_reg;
    assign cache_blk_sel_out         = blk_sel_reg;
    assign blk_valid_out             = blk_valid_reg;
    assign blk_rows_out              = blk_rows_reg;

endmodule

// File: tb/tb_conv_cache_fill_ctrl.sv
// Randomised bench for conv_cache_fill_ctrl against a frame-level model of expected cache writes and bank handovers.
module tb_conv_cache_fill_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int COUNT = 4;
    localparam int AW    = $clog2(DEPTH);
    localparam int RW    = $clog2(COUNT) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start_in = 1'b0;
    logic [AW:0]       row_len_in = '0;
    logic [15:0]       frame_rows_in = '0;
    logic [DW-1:0]     pix_data_in = '0;
    logic              pix_valid_in = 1'b0;
    logic              pix_ready_out;
    logic [DW-1:0]     wrt_data;
    logic [AW-1:0]     wrt_addr;
    logic [COUNT-1:0]  wrt_sel;
    logic              wrt_en;
    logic              blk_sel;
    logic              blk_valid;
    logic [RW-1:0]     blk_rows;
    logic              blk_release_in = 1'b0;
    logic              frame_done;

    int n_cmp = 0;
    int n_fail = 0;
    logic exp_sel_bit = 1'b0;

    conv_cache_fill_ctrl #(.DATA_WIDTH(DW), .IM_CACHE_DEPTH(DEPTH), .IM_CACHE_COUNT(COUNT)) dut (
        .clk(clk), .reset(reset), .start_in(start_in), .row_len_in(row_len_in),
        .frame_rows_in(frame_rows_in), .pix_data_in(pix_data_in), .pix_valid_in(pix_valid_in),
        .pix_ready_out(pix_ready_out), .cache_port_a_wrt_data_out(wrt_data),
        .cache_port_a_wrt_addr_out(wrt_addr), .cache_port_a_wrt_sel_out(wrt_sel),
        .cache_port_a_wrt_en_out(wrt_en), .cache_blk_sel_out(blk_sel), .blk_valid_out(blk_valid),
        .blk_rows_out(blk_rows), .blk_release_in(blk_release_in), .frame_done_out(frame_done)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({pix_ready_out, wrt_en, wrt_sel, wrt_addr, wrt_data, blk_sel, blk_valid, blk_rows, frame_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got ready=%0b en=%0b sel=%0h addr=%0h data=%0h bsel=%0b bvalid=%0b rows=%0d done=%0b required all 0",
                     pix_ready_out, wrt_en, wrt_sel, wrt_addr, wrt_data, blk_sel, blk_valid, blk_rows, frame_done);
        end
        reset = 1'b0;
        @(negedge clk);
        blk_release_in = 1'b1;
        @(negedge clk);
        blk_release_in = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (blk_valid !== 1'b0 || pix_ready_out !== 1'b0 || blk_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_release got bvalid=%0b ready=%0b bsel=%0b required 0 0 0", blk_valid, pix_ready_out, blk_sel);
        end
        exp_sel_bit = 1'b0;
        $display("test_reset done: compared=%0d failed=%0d", n_cmp, n_fail);
    endtask

    // Runs one complete frame: drives pixels and reader releases, checks every write and handover.
    task automatic test_frame(input int rl, input int fr, input int vpct, input int rdmin,
                              input int rdmax, input int exp_lat, input string tag);
        logic [DW-1:0] src[$];
        logic [DW-1:0] ed[$];
        int ea[$];
        int es[$];
        bit ep[$];
        int eb[$];
        int total, nb, acc, cyc, rel_cnt, since_rel, bank_i, rows;
        bit holding, prev_acc, done_seen, rel_drv, prev_rel_drv, new_bank, exp_done, v;
        logic [DW-1:0] d;
        total = rl * fr;
        for (int i = 0; i < total; i++) begin
            d = DW'($urandom);
            src.push_back(d);
            ed.push_back(d);
            ea.push_back(i % rl);
            es.push_back(1 << ((i / rl) % COUNT));
            ep.push_back(1'b0);
        end
        nb = (fr + COUNT - 1) / COUNT;
        for (int b = 0; b < nb; b++) begin
            rows = fr - b * COUNT;
            if (rows > COUNT) rows = COUNT;
`ifdef CONV_CACHE_FILL_ZERO_PAD_EN
            for (int r = rows; r < COUNT; r++)
                for (int c = 0; c < rl; c++) begin
                    ed.push_back('0);
                    ea.push_back(c);
                    es.push_back(1 << r);
                    ep.push_back(1'b1);
                end
            eb.push_back(COUNT);
`else
            eb.push_back(rows);
`endif
        end

        @(negedge clk);
        row_len_in = (AW+1)'(rl);
        frame_rows_in = 16'(fr);
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        acc = 0; cyc = 0; rel_cnt = 0; since_rel = 0; bank_i = 0;
        holding = 0; prev_acc = 0; done_seen = 0; prev_rel_drv = 0;
        while (!(done_seen && !holding) && cyc < 5000) begin
            since_rel++;
            if (prev_acc && wrt_en !== 1'b1) begin
                n_cmp++; n_fail++;
                $display("FAIL %s write_missing got en=%0b required 1 one cycle after accept", tag, wrt_en);
            end
            if (wrt_en === 1'b1) begin
                n_cmp++;
                if (ed.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s write_unexpected got sel=%0h addr=%0d data=%0h required no write", tag, wrt_sel, wrt_addr, wrt_data);
                end else begin
                    if (wrt_data !== ed[0] || int'(wrt_addr) != ea[0] || int'(wrt_sel) != es[0] || (!ep[0] && !prev_acc)) begin
                        n_fail++;
                        $display("FAIL %s write got sel=%0h addr=%0d data=%0h timely=%0b required sel=%0h addr=%0d data=%0h",
                                 tag, wrt_sel, wrt_addr, wrt_data, prev_acc | ep[0], es[0], ea[0], ed[0]);
                    end
                    void'(ed.pop_front()); void'(ea.pop_front()); void'(es.pop_front()); void'(ep.pop_front());
                end
            end
            new_bank = (blk_sel !== exp_sel_bit);
            if (new_bank) begin
                n_cmp++;
                if (bank_i >= nb || holding || blk_valid !== 1'b1 || int'(blk_rows) != eb[bank_i]) begin
                    n_fail++;
                    $display("FAIL %s swap bank=%0d got valid=%0b rows=%0d unreleased=%0b required valid=1 rows=%0d",
                             tag, bank_i, blk_valid, blk_rows, holding, (bank_i < nb) ? eb[bank_i] : -1);
                end
                if (exp_lat > 0 && bank_i > 0) begin
                    n_cmp++;
                    if (since_rel != exp_lat) begin
                        n_fail++;
                        $display("FAIL %s swap_latency got %0d required %0d cycles after release", tag, since_rel, exp_lat);
                    end
                end
                exp_sel_bit = ~exp_sel_bit;
                holding = 1'b1;
                rel_cnt = $urandom_range(rdmax, rdmin);
                bank_i++;
            end
            exp_done = new_bank && (bank_i == nb);
            n_cmp++;
            if (frame_done !== exp_done) begin
                n_fail++;
                $display("FAIL %s frame_done got %0b required %0b (bank %0d of %0d)", tag, frame_done, exp_done, bank_i, nb);
            end
            if (exp_done) begin
                done_seen = 1'b1;
                n_cmp++;
                if (ed.size() != 0 || acc != total) begin
                    n_fail++;
                    $display("FAIL %s done_early got writes_left=%0d accepted=%0d required 0 and %0d", tag, ed.size(), acc, total);
                end
            end
            if (prev_rel_drv && !new_bank) begin
                n_cmp++;
                if (blk_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s valid_after_release got %0b required 0", tag, blk_valid);
                end
            end
            rel_drv = 1'b0;
            if (holding) begin
                if (rel_cnt == 0) begin
                    if (exp_lat > 0 && bank_i < nb) begin
                        n_cmp++;
                        if (pix_ready_out !== 1'b0) begin
                            n_fail++;
                            $display("FAIL %s stall_ready got %0b required 0 while bank held", tag, pix_ready_out);
                        end
                    end
                    rel_drv = 1'b1;
                    holding = 1'b0;
                    since_rel = 0;
                end else begin
                    rel_cnt--;
                end
                blk_release_in = rel_drv;
            end else begin
                blk_release_in = (blk_valid === 1'b0) && ($urandom_range(7, 0) == 0);
            end
            prev_rel_drv = rel_drv;
            v = ($urandom_range(100, 1) <= vpct);
            pix_valid_in = v;
            pix_data_in = (acc < total) ? src[acc] : DW'($urandom);
            prev_acc = v && (pix_ready_out === 1'b1);
            if (prev_acc) begin
                if (acc >= total) begin
                    n_cmp++; n_fail++;
                    $display("FAIL %s extra_accept got beat %0d accepted required at most %0d", tag, acc + 1, total);
                end
                acc++;
            end
            @(negedge clk);
            cyc++;
        end
        blk_release_in = 1'b0;
        pix_valid_in = 1'b0;
        n_cmp++;
        if (!done_seen || bank_i != nb) begin
            n_fail++;
            $display("FAIL %s timeout got banks=%0d done=%0b required banks=%0d done=1 within 5000 cycles", tag, bank_i, done_seen, nb);
        end
        @(negedge clk);
        $display("test_frame %s rl=%0d rows=%0d: compared=%0d failed=%0d", tag, rl, fr, n_cmp, n_fail);
    endtask

    task automatic test_back_to_back();
        test_frame(4, 4, 100, 0, 0, 0, "back_to_back");
    endtask

    task automatic test_wait_swap();
        test_frame(4, 8, 100, 40, 40, 1, "wait_swap");
    endtask

    task automatic test_release_on_entry();
        test_frame(4, 8, 100, 17, 17, 1, "release_on_entry");
    endtask

    task automatic test_pad();
        test_frame(3, 5, 70, 0, 6, 0, "partial_bank");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            test_frame($urandom_range(DEPTH, 1), $urandom_range(10, 1), $urandom_range(100, 30), 0, 12, 0, "random");
    endtask

    task automatic test_reset_midframe();
        int cyc;
        @(negedge clk);
        row_len_in = 5'd2;
        frame_rows_in = 16'd6;
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        cyc = 0;
        while (blk_sel !== 1'b1 && cyc < 200) begin
            pix_valid_in = ($urandom_range(3, 0) != 0);
            pix_data_in = DW'($urandom);
            @(negedge clk);
            cyc++;
        end
        repeat (3) begin
            pix_valid_in = ($urandom_range(1, 0) != 0);
            @(negedge clk);
        end
        pix_valid_in = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (cyc >= 200 || wrt_en !== 1'b0 || blk_sel !== 1'b0 || blk_valid !== 1'b0 || pix_ready_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset got en=%0b bsel=%0b bvalid=%0b ready=%0b swapped=%0b required 0 0 0 0 1",
                     wrt_en, blk_sel, blk_valid, pix_ready_out, cyc < 200);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if (wrt_en !== 1'b0 || pix_ready_out !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle got en=%0b ready=%0b required 0 0", wrt_en, pix_ready_out);
            end
        end
        pix_valid_in = 1'b0;
        exp_sel_bit = 1'b0;
        test_frame(5, 6, 60, 0, 8, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wait_swap();
        test_release_on_entry();
        test_pad();
        test_random();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
